// File: rtl/wb_regfile_pkg.sv
// Shared write-back definitions: datapath widths and wb_ctrl bit positions used
// by the controller, the pipeline registers and the write-back stage.
package wb_regfile_pkg;

  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned REG_ADDR_WIDTH = 5;
  localparam int unsigned WB_CTRL_WIDTH  = 2;

  localparam int unsigned WB_REGWRITE_BIT = 1;
  localparam int unsigned WB_MEMTOREG_BIT = 0;

endpackage

// File: rtl/wb_regfile_2r1w.sv
// Architectural register storage: one synchronous write port, two combinational
// read ports, x0 hardwired to zero.
module wb_regfile_2r1w
  import wb_regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_WIDTH,
  parameter int unsigned ADDR_W   = REG_ADDR_WIDTH,
  parameter int unsigned NUM_REGS = 2 ** ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o
);

  logic [DATA_W-1:0] mem [NUM_REGS];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata1_o = (raddr1_i == '0) ? '0 : mem[raddr1_i];
    rdata2_o = (raddr2_i == '0) ? '0 : mem[raddr2_i];
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: load/ALU select, commit into the register file, forwarding
// outputs and a retired-write counter. Optional WB_REGFILE_BYPASS_EN forwards the
// committing value onto the read ports in the same cycle.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_WIDTH,
  parameter int unsigned ADDR_W   = REG_ADDR_WIDTH,
  parameter int unsigned NUM_REGS = 2 ** ADDR_W
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [WB_CTRL_WIDTH-1:0] wb_ctrl_i,
  input  logic [DATA_W-1:0]        read_data_i,
  input  logic [DATA_W-1:0]        result_i,
  input  logic [ADDR_W-1:0]        rd_i,
  input  logic [ADDR_W-1:0]        rs1_addr_i,
  input  logic [ADDR_W-1:0]        rs2_addr_i,
  output logic [DATA_W-1:0]        rs1_data_o,
  output logic [DATA_W-1:0]        rs2_data_o,
  output logic [DATA_W-1:0]        wb_data_o,
  output logic                     wb_we_o,
  output logic [31:0]              wb_cnt_o
);

  logic [DATA_W-1:0] wb_data;
  logic              wb_we;
  logic [DATA_W-1:0] arr_rdata1;
  logic [DATA_W-1:0] arr_rdata2;
  logic [31:0]       cnt_q;

  // Writes to x0 are dropped here so they neither commit nor count.
  always_comb begin
    wb_data = wb_ctrl_i[WB_MEMTOREG_BIT] ? read_data_i : result_i;
    wb_we   = wb_ctrl_i[WB_REGWRITE_BIT] && (rd_i != '0);
  end

  wb_regfile_2r1w #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_regs (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .we_i     (wb_we),
    .waddr_i  (rd_i),
    .wdata_i  (wb_data),
    .raddr1_i (rs1_addr_i),
    .raddr2_i (rs2_addr_i),
    .rdata1_o (arr_rdata1),
    .rdata2_o (arr_rdata2)
  );

  always_comb begin
    rs1_data_o = arr_rdata1;
    rs2_data_o = arr_rdata2;
`ifdef WB_REGFILE_BYPASS_EN
    // wb_we already excludes rd_i == 0, so x0 reads stay zero.
    if (wb_we && (rs1_addr_i == rd_i)) rs1_data_o = wb_data;
    if (wb_we && (rs2_addr_i == rd_i)) rs2_data_o = wb_data;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (wb_we) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign wb_data_o = wb_data;
  assign wb_we_o   = wb_we;
  assign wb_cnt_o  = cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed steps plus randomized traffic,
// checked against an array/counter reference model.
module tb_wb_regfile;
  import wb_regfile_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 32;
`ifdef WB_REGFILE_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    wb_ctrl;
  logic [DW-1:0] read_data;
  logic [DW-1:0] result;
  logic [AW-1:0] rd;
  logic [AW-1:0] rs1_addr;
  logic [AW-1:0] rs2_addr;
  logic [DW-1:0] rs1_data;
  logic [DW-1:0] rs2_data;
  logic [DW-1:0] wb_data;
  logic          wb_we;
  logic [31:0]   wb_cnt;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] mregs [NR];
  logic [31:0]   mcnt;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .wb_ctrl_i   (wb_ctrl),
    .read_data_i (read_data),
    .result_i    (result),
    .rd_i        (rd),
    .rs1_addr_i  (rs1_addr),
    .rs2_addr_i  (rs2_addr),
    .rs1_data_o  (rs1_data),
    .rs2_data_o  (rs2_data),
    .wb_data_o   (wb_data),
    .wb_we_o     (wb_we),
    .wb_cnt_o    (wb_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_wb();
    return wb_ctrl[0] ? read_data : result;
  endfunction

  function automatic logic exp_we();
    return wb_ctrl[1] && (rd != 0);
  endfunction

  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (Bypass && exp_we() && (a == rd)) return exp_wb();
    return mregs[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NR; i++) mregs[i] = '0;
    mcnt = '0;
  endtask

  task automatic set_in(input logic [1:0] c, input logic [AW-1:0] d, input logic [DW-1:0] ld,
                        input logic [DW-1:0] res, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    wb_ctrl = c; rd = d; read_data = ld; result = res; rs1_addr = a1; rs2_addr = a2;
  endtask

  // Inputs change on the negedge, like the MEM/WB register feeding this stage.
  task automatic apply(input logic [1:0] c, input logic [AW-1:0] d, input logic [DW-1:0] ld,
                       input logic [DW-1:0] res, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    @(negedge clk);
    set_in(c, d, ld, res, a1, a2);
    #1;
  endtask

  task automatic check_comb(input string tag);
    check({tag, "_rs1"}, rs1_data, exp_read(rs1_addr));
    check({tag, "_rs2"}, rs2_data, exp_read(rs2_addr));
    check({tag, "_wbdata"}, wb_data, exp_wb());
    check({tag, "_wbwe"}, {31'd0, wb_we}, {31'd0, exp_we()});
  endtask

  task automatic commit(input string tag);
    @(posedge clk);
    if (exp_we()) begin
      mregs[rd] = exp_wb();
      mcnt      = mcnt + 32'd1;
    end
    #1;
    check({tag, "_cnt"}, wb_cnt, mcnt);
  endtask

  task automatic step(input string tag, input logic [1:0] c, input logic [AW-1:0] d,
                      input logic [DW-1:0] ld, input logic [DW-1:0] res,
                      input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    apply(c, d, ld, res, a1, a2);
    check_comb({tag, "_pre"});
    commit(tag);
    check_comb({tag, "_post"});
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(2'b00, '0, '0, '0, '0, '0);
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset clears previously written contents and discards a pending write.
    step("wr5", 2'b10, 5'd5, '0, 32'hDEAD_BEEF, 5'd5, 5'd31);
    check("wr5_val", rs1_data, 32'hDEAD_BEEF);
    apply(2'b10, 5'd6, '0, 32'h1111_1111, 5'd5, 5'd31);
    #2 rst_n = 1'b0;
    model_clear();
    #1;
    check("rst_rs1", rs1_data, 32'h0);
    check("rst_rs2", rs2_data, 32'h0);
    check("rst_cnt", wb_cnt, 32'h0);
    check("rst_wbdata", wb_data, 32'h1111_1111);
    @(posedge clk);
    #1;
    check("rst_hold_rs1", rs1_data, 32'h0);
    check("rst_hold_cnt", wb_cnt, 32'h0);

    // First write after release commits at the first posedge with rst_ni high.
    @(negedge clk);
    rst_n = 1'b1;
    set_in(2'b11, 5'd10, 32'h0000_0077, 32'h0, 5'd10, 5'd6);
    #1;
    check_comb("rel_pre");
    commit("rel");
    check("rel_r10", rs1_data, 32'h77);
    check("rel_r6", rs2_data, 32'h0);
    check("rel_cnt1", wb_cnt, 32'd1);

    // Write-back mux selects load data then ALU result.
    step("mux7", 2'b11, 5'd7, 32'h1234_5678, 32'hAAAA_0000, 5'd7, 5'd8);
    step("mux8", 2'b10, 5'd8, 32'h1234_5678, 32'h0000_00FF, 5'd7, 5'd8);
    check("mux_r7", rs1_data, 32'h1234_5678);
    check("mux_r8", rs2_data, 32'h0000_00FF);
    check("mux_cnt", wb_cnt, 32'd3);

    // x0 write is dropped and uncounted.
    apply(2'b10, 5'd0, '0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    check("x0_we", {31'd0, wb_we}, 32'd0);
    check("x0_rs1", rs1_data, 32'h0);
    commit("x0");
    check("x0_cnt", wb_cnt, 32'd3);
    check("x0_rs1_post", rs1_data, 32'h0);

    // Bubble and MemtoReg-without-RegWrite perform no write.
    step("pre3", 2'b10, 5'd3, '0, 32'h0000_0033, 5'd3, 5'd3);
    apply(2'b00, 5'd3, '0, 32'h0000_0055, 5'd3, 5'd3);
    check("bub_wbdata", wb_data, 32'h55);
    commit("bub");
    check("bub_r3", rs1_data, 32'h33);
    check("bub_cnt", wb_cnt, 32'd4);
    step("m2r", 2'b01, 5'd4, 32'h0000_0099, 32'h0000_0011, 5'd4, 5'd3);
    check("m2r_wbdata", wb_data, 32'h99);
    check("m2r_r4", rs1_data, 32'h0);

    // Same-cycle read of the register being committed.
    step("pre9", 2'b10, 5'd9, '0, 32'h0000_0001, 5'd1, 5'd2);
    apply(2'b10, 5'd9, '0, 32'h0000_CAFE, 5'd9, 5'd9);
    check("byp_rs1", rs1_data, Bypass ? 32'h0000_CAFE : 32'h0000_0001);
    check("byp_rs2", rs2_data, Bypass ? 32'h0000_CAFE : 32'h0000_0001);
    commit("byp");
    check("byp_post", rs1_data, 32'h0000_CAFE);

    // Counter wraps rather than saturating.
    @(negedge clk);
    set_in(2'b00, '0, '0, '0, '0, '0);
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1 release dut.cnt_q;
    mcnt = 32'hFFFF_FFFF;
    #1;
    check("wrap_pre", wb_cnt, 32'hFFFF_FFFF);
    step("wrap", 2'b10, 5'd12, '0, 32'h0000_0012, 5'd12, 5'd0);
    check("wrap_cnt", wb_cnt, 32'h0);

    // Randomized traffic; reads often alias the destination to exercise forwarding.
    for (int i = 0; i < 300; i++) begin
      logic [AW-1:0] d;
      logic [AW-1:0] a1;
      logic [AW-1:0] a2;
      d  = AW'($urandom_range(0, NR - 1));
      a1 = ($urandom_range(0, 3) == 0) ? d : AW'($urandom_range(0, NR - 1));
      a2 = ($urandom_range(0, 3) == 0) ? d : AW'($urandom_range(0, NR - 1));
      step("rnd", 2'($urandom_range(0, 3)), d, $urandom, $urandom, a1, a2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
